// File: rtl/wt_dcache_mem_responder.sv
// wt_dcache_mem_responder
//
// Memory-side end-point for the write-through data cache's memory port.
// It accepts tagged load (full cacheline) and store (64-bit, byte-masked)
// requests, services them from an internal line-organised SRAM, and returns
// tagged responses in acceptance order through a credit-protected FIFO.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_valid_i        request valid; accepted when req_ready_o is also high
//   req_ready_o        credit available (registered state only)
//   req_type_i         0 = load, 1 = store
//   req_tid_i          transaction ID, echoed in the response
//   req_paddr_i        physical byte address
//   req_wdata_i        store data
//   req_be_i           store byte enables
//   resp_valid_o       FIFO head holds a response
//   resp_ready_i       response consumed when valid && ready
//   resp_type_o        echoed request type
//   resp_tid_o         echoed transaction ID
//   resp_rdata_o       load line data; zero for stores and errors
//   resp_err_o         address outside [BaseAddr, BaseAddr+MemBytes)
//   outstanding_o      FIFO occupancy plus in-flight request
module wt_dcache_mem_responder #(
  parameter int unsigned MemTidWidth = 2,
  parameter int unsigned LineWidth   = 128,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned MemBytes    = 16384,
  parameter logic [63:0] BaseAddr    = 64'h8000_0000,
  parameter int unsigned RespDepth   = 4,
  parameter bit          BigEndian   = 1'b1,
  localparam int unsigned CntWidth   = $clog2(RespDepth + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_type_i,
  input  logic [MemTidWidth-1:0] req_tid_i,
  input  logic [AddrWidth-1:0]   req_paddr_i,
  input  logic [63:0]            req_wdata_i,
  input  logic [7:0]             req_be_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic                   resp_type_o,
  output logic [MemTidWidth-1:0] resp_tid_o,
  output logic [LineWidth-1:0]   resp_rdata_o,
  output logic                   resp_err_o,
  output logic [CntWidth-1:0]    outstanding_o
);

  localparam int unsigned LineBytes = LineWidth / 8;
  localparam int unsigned OffBits   = $clog2(LineBytes);
  localparam int unsigned NumLines  = MemBytes / LineBytes;
  localparam int unsigned MemBits   = $clog2(MemBytes);
  localparam int unsigned IdxBits   = MemBits - OffBits;
  localparam int unsigned Lanes     = LineWidth / 64;
  localparam int unsigned LaneW     = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam int unsigned PtrW      = (RespDepth > 1) ? $clog2(RespDepth) : 1;

  function automatic logic [63:0] swap64(input logic [63:0] d);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = d[(7-k)*8 +: 8];
    return r;
  endfunction

  function automatic logic [7:0] swap8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RespDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [LineWidth-1:0] mem_q [NumLines];

  logic                   inflight_q;
  logic                   ib_type_q;
  logic [MemTidWidth-1:0] ib_tid_q;
  logic [LineWidth-1:0]   ib_rdata_q;
  logic                   ib_err_q;

  logic                   fifo_type_q  [RespDepth];
  logic [MemTidWidth-1:0] fifo_tid_q   [RespDepth];
  logic [LineWidth-1:0]   fifo_rdata_q [RespDepth];
  logic                   fifo_err_q   [RespDepth];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]    count_q, count_d;

  logic                 accept, in_range, pop, wr_en;
  logic [IdxBits-1:0]   line_idx;
  logic [LaneW-1:0]     lane_idx;
  logic [LineWidth-1:0] rd_line, a_rdata_d;
  logic [63:0]          wdata_lane;
  logic [7:0]           be_lane;
  logic [CntWidth-1:0]  outstanding;
  logic                 unused_paddr_bits;

  assign unused_paddr_bits = ^req_paddr_i[2:0];

  // Credits come from registered state only, so a pop in this cycle
  // frees its credit one cycle later.
  assign outstanding   = count_q + CntWidth'(inflight_q);
  assign outstanding_o = outstanding;
  assign req_ready_o   = outstanding < CntWidth'(RespDepth);

  // A request presented while reset is asserted is never taken.
  assign accept = req_valid_i && req_ready_o && !rst_i;

  // BaseAddr is aligned to MemBytes, so range check is a compare of the
  // address bits above the SRAM offset.
  assign in_range = req_paddr_i[AddrWidth-1:MemBits] == AddrWidth'(BaseAddr) >> MemBits;
  assign line_idx = req_paddr_i[MemBits-1:OffBits];

  if (Lanes > 1) begin : g_lane
    assign lane_idx = req_paddr_i[OffBits-1:3];
  end else begin : g_nolane
    assign lane_idx = '0;
  end

  // Stage A: SRAM read, endian adjustment and response data for the
  // request being accepted this cycle.
  always_comb begin
    rd_line    = mem_q[line_idx];
    wdata_lane = BigEndian ? swap64(req_wdata_i) : req_wdata_i;
    be_lane    = BigEndian ? swap8(req_be_i) : req_be_i;
    a_rdata_d  = '0;
    if (!req_type_i && in_range) begin
      for (int l = 0; l < Lanes; l++)
        a_rdata_d[l*64 +: 64] = BigEndian ? swap64(rd_line[l*64 +: 64]) : rd_line[l*64 +: 64];
    end
  end

  assign wr_en = accept && req_type_i && in_range;

  // Store commit at the end of the acceptance cycle, so a load accepted
  // on the next cycle already sees it. SRAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++)
        if (be_lane[b])
          mem_q[line_idx][int'(lane_idx)*64 + b*8 +: 8] <= wdata_lane[b*8 +: 8];
    end
  end

  assign pop     = resp_valid_o && resp_ready_i;
  assign count_d = count_q + CntWidth'(inflight_q) - CntWidth'(pop);

  // Stage B register and response FIFO. The in-flight entry is pushed on
  // the edge after acceptance; credits guarantee a free slot for it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      ib_type_q  <= 1'b0;
      ib_tid_q   <= '0;
      ib_rdata_q <= '0;
      ib_err_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        ib_type_q  <= req_type_i;
        ib_tid_q   <= req_tid_i;
        ib_rdata_q <= a_rdata_d;
        ib_err_q   <= !in_range;
      end
      if (inflight_q) begin
        fifo_type_q[wr_ptr_q]  <= ib_type_q;
        fifo_tid_q[wr_ptr_q]   <= ib_tid_q;
        fifo_rdata_q[wr_ptr_q] <= ib_rdata_q;
        fifo_err_q[wr_ptr_q]   <= ib_err_q;
        wr_ptr_q               <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Outputs read straight from the head entry; forced to zero when the
  // FIFO is empty so reset shows all-zero response fields.
  assign resp_valid_o = count_q != '0;
  assign resp_type_o  = resp_valid_o & fifo_type_q[rd_ptr_q];
  assign resp_tid_o   = resp_valid_o ? fifo_tid_q[rd_ptr_q] : '0;
  assign resp_rdata_o = resp_valid_o ? fifo_rdata_q[rd_ptr_q] : '0;
  assign resp_err_o   = resp_valid_o & fifo_err_q[rd_ptr_q];

endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// Testbench for wt_dcache_mem_responder: a byte-array memory model plus an
// ordered queue of expected responses, checked every cycle by one monitor.
module tb_wt_dcache_mem_responder;

  localparam int unsigned TidW  = 2;
  localparam int unsigned LineW = 128;
  localparam int unsigned AddrW = 64;
  localparam int unsigned MemB  = 16384;
  localparam logic [63:0] Base  = 64'h8000_0000;
  localparam int unsigned Depth = 4;
  localparam bit          BigEnd = 1'b1;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              reqValid, reqReady, reqType;
  logic [TidW-1:0]   reqTid;
  logic [AddrW-1:0]  reqAddr;
  logic [63:0]       reqWdata;
  logic [7:0]        reqBe;
  logic              respValid, respReady, respType, respErr;
  logic [TidW-1:0]   respTid;
  logic [LineW-1:0]  respRdata;
  logic [CntW-1:0]   outstanding;

  always #5 clk = ~clk;

  wt_dcache_mem_responder #(
    .MemTidWidth(TidW), .LineWidth(LineW), .AddrWidth(AddrW), .MemBytes(MemB),
    .BaseAddr(Base), .RespDepth(Depth), .BigEndian(BigEnd)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_type_i(reqType),
    .req_tid_i(reqTid), .req_paddr_i(reqAddr), .req_wdata_i(reqWdata), .req_be_i(reqBe),
    .resp_valid_o(respValid), .resp_ready_i(respReady), .resp_type_o(respType),
    .resp_tid_o(respTid), .resp_rdata_o(respRdata), .resp_err_o(respErr),
    .outstanding_o(outstanding)
  );

  typedef struct {
    logic             rtype;
    logic [TidW-1:0]  tid;
    logic [LineW-1:0] rdata;
    logic             err;
  } resp_t;

  resp_t       expQ[$];
  resp_t       gotLog[$];
  logic [7:0]  modelMem [MemB];
  int          vectors = 0;
  int          miscompares = 0;
  int          acceptCount = 0;
  bit          inflightModel = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] pattern(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'h0BAD_0000 + 32'(i * 7)};
  endfunction

  // Reference behaviour: SRAM bytes kept in storage order; a big-endian
  // port reverses byte positions within each 64-bit lane on the way in
  // and on the way out.
  task automatic modelAccess(input logic t, input logic [TidW-1:0] tid, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [7:0] be, output resp_t r);
    int off, lineBase, laneBase, k;
    r.rtype = t;
    r.tid   = tid;
    r.rdata = '0;
    r.err   = 1'b0;
    if (addr < Base || addr >= Base + 64'(MemB)) begin
      r.err = 1'b1;
    end else begin
      off      = int'(addr - Base);
      lineBase = (off / 16) * 16;
      laneBase = lineBase + ((off / 8) % 2) * 8;
      if (t) begin
        for (int b = 0; b < 8; b++)
          if (be[b]) modelMem[laneBase + (BigEnd ? 7 - b : b)] = wd[8*b +: 8];
      end else begin
        for (int b = 0; b < 16; b++) begin
          k = b % 8;
          r.rdata[8*b +: 8] = modelMem[lineBase + (b / 8) * 8 + (BigEnd ? 7 - k : k)];
        end
      end
    end
  endtask

  // Monitor: checks credits, occupancy and head validity every cycle, and
  // compares each consumed response with the oldest expected one.
  always @(negedge clk) begin : monitor
    resp_t e, g;
    logic  acc;
    if (rst) begin
      expQ.delete();
      inflightModel = 1'b0;
    end else begin
      checkOutput("outstanding", 128'(outstanding), 128'(expQ.size()));
      checkOutput("req_ready", 128'(reqReady), 128'(expQ.size() < Depth));
      checkOutput("resp_valid", 128'(respValid), 128'((expQ.size() - int'(inflightModel)) > 0));
      if (respValid && respReady) begin
        g.rtype = respType; g.tid = respTid; g.rdata = respRdata; g.err = respErr;
        gotLog.push_back(g);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", 128'(1), 128'(0));
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_type", 128'(g.rtype), 128'(e.rtype));
          checkOutput("resp_tid", 128'(g.tid), 128'(e.tid));
          checkOutput("resp_rdata", g.rdata, e.rdata);
          checkOutput("resp_err", 128'(g.err), 128'(e.err));
        end
      end
      acc = reqValid && reqReady;
      if (acc) begin
        modelAccess(reqType, reqTid, reqAddr, reqWdata, reqBe, e);
        expQ.push_back(e);
        acceptCount++;
      end
      inflightModel = acc;
    end
  end

  // Holds one request until accepted (bounded); called and returns just
  // after a rising edge.
  task automatic applyStimulus(input logic t, input logic [TidW-1:0] tid, input logic [63:0] addr,
                               input logic [63:0] wd, input logic [7:0] be);
    int n = 0;
    reqValid = 1'b1; reqType = t; reqTid = tid; reqAddr = addr; reqWdata = wd; reqBe = be;
    forever begin
      @(negedge clk);
      if (reqReady) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) checkOutput("accept_timeout", 128'(1), 128'(0));
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    respReady = 1'b1;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) checkOutput("drain_timeout", 128'(1), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int          logStart, a0;
    logic [63:0] p0, oorList [4];
    logic [LineW-1:0] line0;

    rst = 1'b1; reqValid = 1'b0; reqType = 1'b0; reqTid = '0; reqAddr = '0;
    reqWdata = '0; reqBe = '0; respReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_outstanding", 128'(outstanding), 128'(0));
    checkOutput("rst_resp_valid", 128'(respValid), 128'(0));
    checkOutput("rst_req_ready", 128'(reqReady), 128'(1));
    checkOutput("rst_resp_fields", {respRdata[123:0], respType, respTid, respErr}, 128'(0));
    @(posedge clk); #1;

    // Fill the first 16 lines with a known pattern.
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, TidW'(i), Base + 64'(i * 8), pattern(i), 8'hFF);
    waitDrain();

    // Store then back-to-back load of the same line.
    logStart = gotLog.size();
    applyStimulus(1'b1, 2'd1, 64'h8000_0008, 64'h1122334455667788, 8'hFF);
    applyStimulus(1'b0, 2'd2, 64'h8000_0000, 64'h0, 8'h00);
    waitDrain();
    checkOutput("raw_count", 128'(gotLog.size() - logStart), 128'(2));
    if (gotLog.size() >= logStart + 2) begin
      checkOutput("raw_st_tid", 128'(gotLog[logStart].tid), 128'(1));
      checkOutput("raw_st_rdata", gotLog[logStart].rdata, 128'(0));
      checkOutput("raw_ld_tid", 128'(gotLog[logStart+1].tid), 128'(2));
      checkOutput("raw_ld_hi", 128'(gotLog[logStart+1].rdata[127:64]), 128'(64'h1122334455667788));
    end

    // Single-byte store through the byte-swapping port; the load path
    // swaps back, so the byte reappears at bus byte 0.
    p0 = pattern(0);
    line0 = {64'h1122334455667788, p0[63:8], 8'hAA};
    logStart = gotLog.size();
    applyStimulus(1'b1, 2'd3, Base, 64'hAA, 8'h01);
    applyStimulus(1'b0, 2'd0, Base, 64'h0, 8'h00);
    waitDrain();
    if (gotLog.size() >= logStart + 2)
      checkOutput("endian_line", gotLog[logStart+1].rdata, line0);
    else
      checkOutput("endian_count", 128'(gotLog.size() - logStart), 128'(2));

    // Backpressure: six requests, only four credits.
    respReady = 1'b0;
    a0 = acceptCount;
    logStart = gotLog.size();
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, TidW'(i), Base + 64'(16 * i), 64'h0, 8'h00);
      end
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_accepted", 128'(acceptCount - a0), 128'(4));
        checkOutput("bp_ready_low", 128'(reqReady), 128'(0));
        checkOutput("bp_outstanding", 128'(outstanding), 128'(4));
        @(posedge clk); #1;
        respReady = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bp_total", 128'(acceptCount - a0), 128'(6));
    if (gotLog.size() >= logStart + 6)
      for (int i = 0; i < 6; i++) checkOutput("bp_tid_order", 128'(gotLog[logStart+i].tid), 128'(i % 4));

    // Full FIFO with continuous push and pop across pointer wrap.
    respReady = 1'b0;
    logStart = gotLog.size();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, TidW'(i), Base + 64'(16 * i), 64'h0, 8'h00);
    respReady = 1'b1;
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, TidW'(i), Base + 64'(16 * (i % 16)), 64'h0, 8'h00);
    waitDrain();
    checkOutput("full_resp_count", 128'(gotLog.size() - logStart), 128'(18));

    // Out-of-range load and store, then confirm line 0 untouched.
    logStart = gotLog.size();
    applyStimulus(1'b0, 2'd1, 64'h7FFF_FFF0, 64'h0, 8'h00);
    applyStimulus(1'b1, 2'd2, Base + 64'(MemB), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    applyStimulus(1'b0, 2'd3, Base, 64'h0, 8'h00);
    waitDrain();
    if (gotLog.size() >= logStart + 3) begin
      checkOutput("err_ld_err", 128'(gotLog[logStart].err), 128'(1));
      checkOutput("err_ld_rdata", gotLog[logStart].rdata, 128'(0));
      checkOutput("err_st_err", 128'(gotLog[logStart+1].err), 128'(1));
      checkOutput("err_st_rdata", gotLog[logStart+1].rdata, 128'(0));
      checkOutput("err_mem_kept", gotLog[logStart+2].rdata, line0);
    end else begin
      checkOutput("err_count", 128'(gotLog.size() - logStart), 128'(3));
    end

    // Random traffic against the model.
    oorList[0] = Base - 64'd8;
    oorList[1] = Base + 64'(MemB);
    oorList[2] = 64'h0;
    oorList[3] = Base + 64'(MemB) + 64'h100;
    for (int c = 0; c < 400; c++) begin
      reqValid  = ($urandom_range(0, 3) != 0);
      reqType   = 1'($urandom_range(0, 1));
      reqTid    = TidW'($urandom);
      reqWdata  = {$urandom, $urandom};
      reqBe     = 8'($urandom);
      reqAddr   = ($urandom_range(0, 7) == 0) ? oorList[$urandom_range(0, 3)]
                                              : Base + 64'($urandom_range(0, 255));
      respReady = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    reqValid = 1'b0;
    waitDrain();

    // Reset with a load in flight: nothing may come out for it.
    logStart = gotLog.size();
    applyStimulus(1'b0, 2'd2, Base, 64'h0, 8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_outstanding", 128'(outstanding), 128'(0));
    checkOutput("mid_rst_resp_valid", 128'(respValid), 128'(0));
    checkOutput("mid_rst_req_ready", 128'(reqReady), 128'(1));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid_rst_no_resp", 128'(gotLog.size() - logStart), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
